ysyx23060136_ifu_fetch_ctrl: RTL and testbench
==============================================

# ysyx23060136_ifu_fetch_ctrl

Fetch sequencer for IFU1. It issues one instruction-memory read at a time for the PC held by the IFU1 PC counter, and gates that counter through its stall input. It discards responses made stale by a branch redirect and buffers one fetched instruction for the IFU→IDU handshake. It sits between the PC counter, the instruction memory port and the IDU.

## Interface
- BITS_W, 32: PC, address and instruction width.

- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- IFU1_pc  in  BITS_W  current PC from the PC counter
- BRANCH_PCSrc  in  1  redirect; the PC counter loads the branch target in any cycle where this block drives stall low
- IFU_stallIF  out  1  drives FORWARD_stallIF of the PC counter
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  BITS_W  request address (= IFU1_pc)
- mem_resp_valid  in  1  read data valid
- mem_resp_ready  out  1  block accepts data
- mem_resp_data  in  BITS_W  instruction word
- mem_resp_err  in  1  access fault for this response
- IFU_valid  out  1  output buffer holds an instruction
- IDU_ready  in  1  IDU consumes output this cycle
- IFU_inst, IFU_pc  out  BITS_W each  buffered instruction and its address
- IFU_err  out  1  buffered access-fault flag

## Operation
- The block has four states:
  - IDLE: the reset state. It goes to REQ unconditionally on the first clock after reset release.
  - REQ: mem_req_valid=1 and mem_req_addr=IFU1_pc, which stays stable because the PC is stalled. On mem_req_valid && mem_req_ready the block latches req_pc=IFU1_pc and goes to WAIT.
  - WAIT: mem_resp_ready = !IFU_valid || IDU_ready. A response is accepted on mem_resp_valid && mem_resp_ready.
    - If kill=1 or BRANCH_PCSrc=1 in the accept cycle, the data is discarded, kill is cleared and the block goes to REQ.
    - Otherwise the block loads IFU_inst=mem_resp_data, IFU_pc=req_pc and IFU_err=mem_resp_err, sets IFU_valid=1 and goes to REQ.
- Redirect (BRANCH_PCSrc=1) is honoured in every state:
  - IFU_stallIF=0 that cycle, so the PC takes the target.
  - IFU_valid is cleared next cycle, overriding any same-cycle consume or load.
  - In REQ, mem_req_valid is forced to 0 that cycle and the block stays in REQ. No handshake can occur in this cycle.
  - In WAIT without an accept, kill is set.
  - In IDLE, there is no other effect.
- Stall: IFU_stallIF = !(BRANCH_PCSrc || non-discarded response accept). The PC therefore advances +4 exactly once per delivered instruction.
- Output: IFU_valid && IDU_ready consumes the buffer. IFU_valid falls next cycle unless a new response is loaded in the same cycle.
- At most one request is outstanding. A request is never issued while in WAIT.
- Errors: IFU_err travels with its instruction. The block does not stop fetching on an error; the IDU/trap logic decides.
- mem_resp_valid outside WAIT is a protocol violation and is ignored, since mem_resp_ready=0 there.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, kill=0
  - IFU_valid=0, IFU_inst=0, IFU_pc=0, IFU_err=0, req_pc=0
  - outputs during reset: IFU_stallIF=1, mem_req_valid=0, mem_resp_ready=0
- Reset during WAIT abandons the outstanding request. The bench memory is reset with the block.
- Latency:
  - The first mem_req_valid appears in the 2nd clock cycle after reset release.
  - A response accepted in cycle N gives IFU_valid=1 in N+1 and mem_req_valid=1 in N+1.
- Peak throughput is one instruction per 2 cycles, with single-cycle memory and IDU_ready=1.
- Backpressure: while IFU_valid=1 && IDU_ready=0 in WAIT, mem_resp_ready=0 and the response waits in memory.
- Simultaneous events:
  - Redirect and response accept in the same cycle: discard, PC loads the target.
  - Redirect and IDU consume in the same cycle: buffer cleared.
  - Response accept and consume in the same cycle: buffer replaced, IFU_valid stays 1.

## Test plan
- Reset release, IFU1_pc=0x80000000, memory ready with 1-cycle data 0x00000413:
  - mem_req_valid rises in cycle 2 with addr 0x80000000.
  - IFU_valid=1 with IFU_inst=0x00000413 and IFU_pc=0x80000000.
  - IFU_stallIF=0 for exactly one cycle.
- Streaming with IDU_ready=1: addresses 0x80000000, 0x80000004, 0x80000008 are issued. IFU_valid pulses every 2 cycles and the PC increments exactly once per instruction.
- Redirect in WAIT, with the response arriving 3 cycles later:
  - IFU_stallIF=0 in the redirect cycle only.
  - The late response is dropped, with IFU_valid staying 0.
  - The next request uses the new IFU1_pc=0x80001000.
- Redirect in the same cycle as mem_resp_valid: the data is discarded, IFU_valid stays 0 and the request goes to the target next cycle.
- IDU_ready=0 for 5 cycles with IFU_valid=1 and the next response pending:
  - mem_resp_ready=0 throughout and IFU_inst is unchanged.
  - When IDU_ready rises, the buffer is consumed and refilled in the same cycle.
- mem_resp_err=1 on 0x80000010: IFU_err=1 with IFU_pc=0x80000010. Fetch continues at 0x80000014. rst asserted mid-WAIT zeroes all outputs immediately.

Source files
------------

// File: rtl/ysyx23060136_ifu_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ysyx23060136_ifu_fetch_ctrl                                  |
// | Description : IFU1 fetch sequencer. Issues one instruction-memory read at  |
// |               a time for the PC held by the PC counter, gates that counter |
// |               through its stall input, drops responses made stale by a     |
// |               branch redirect and buffers one instruction for the IDU.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk             system clock, all state on posedge                       |
// |   rst             asynchronous, active-low reset                           |
// |   IFU1_pc         current PC from the PC counter                           |
// |   BRANCH_PCSrc    redirect; PC counter loads target when stall is low      |
// |   IFU_stallIF     stall for the PC counter                                 |
// |   mem_req_*       read request channel (valid/ready/addr)                  |
// |   mem_resp_*      read response channel (valid/ready/data/err)             |
// |   IFU_valid       output buffer holds an instruction                       |
// |   IDU_ready       IDU consumes the buffer this cycle                       |
// |   IFU_inst/pc/err buffered instruction, its address and access-fault flag  |
// +----------------------------------------------------------------------------+
module ysyx23060136_ifu_fetch_ctrl #(
  parameter int BITS_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_W-1:0] IFU1_pc,
  input  logic              BRANCH_PCSrc,
  output logic              IFU_stallIF,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [BITS_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [BITS_W-1:0] mem_resp_data,
  input  logic              mem_resp_err,
  output logic              IFU_valid,
  input  logic              IDU_ready,
  output logic [BITS_W-1:0] IFU_inst,
  output logic [BITS_W-1:0] IFU_pc,
  output logic              IFU_err
);

  // S_KILL is "waiting for a response that a redirect has already made
  // stale": it encodes the kill flag, so kill clears whenever S_KILL is left.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_KILL = 2'd3
  } state_t;

  state_t              r_state;
  logic [BITS_W-1:0]   r_req_pc;
  logic                r_valid;
  logic [BITS_W-1:0]   r_inst;
  logic [BITS_W-1:0]   r_pc;
  logic                r_err;

  logic w_waiting;
  logic w_resp_ready;
  logic w_accept;
  logic w_deliver;
  logic w_req_valid;

  assign w_waiting    = (r_state == S_WAIT) || (r_state == S_KILL);
  // A response may only land when the buffer is free or being drained now.
  assign w_resp_ready = w_waiting && (!r_valid || IDU_ready);
  assign w_accept     = mem_resp_valid && w_resp_ready;
  // Only a response that no redirect has touched reaches the buffer.
  assign w_deliver    = w_accept && (r_state == S_WAIT) && !BRANCH_PCSrc;
  // The PC is about to change on a redirect, so no request may use it.
  assign w_req_valid  = (r_state == S_REQ) && !BRANCH_PCSrc;

  // Release the PC counter exactly once per delivered instruction, or to
  // take a branch target. Held stalled while reset is asserted.
  assign IFU_stallIF    = !(rst && (BRANCH_PCSrc || w_deliver));
  assign mem_req_valid  = w_req_valid;
  assign mem_req_addr   = IFU1_pc;
  assign mem_resp_ready = w_resp_ready;
  assign IFU_valid      = r_valid;
  assign IFU_inst       = r_inst;
  assign IFU_pc         = r_pc;
  assign IFU_err        = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_req_pc <= '0;
      r_valid  <= 1'b0;
      r_inst   <= '0;
      r_pc     <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (w_req_valid && mem_req_ready) begin
            r_req_pc <= IFU1_pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_accept) begin
            r_state <= S_REQ;
          end else if (BRANCH_PCSrc) begin
            r_state <= S_KILL;
          end
        end
        S_KILL: begin
          if (w_accept) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Redirect flushes the buffer and wins over a same-cycle load/consume.
      if (BRANCH_PCSrc) begin
        r_valid <= 1'b0;
      end else if (w_deliver) begin
        r_valid <= 1'b1;
        r_inst  <= mem_resp_data;
        r_pc    <= r_req_pc;
        r_err   <= mem_resp_err;
      end else if (r_valid && IDU_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx23060136_ifu_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ysyx23060136_ifu_fetch_ctrl                               |
// | Description : Randomized bench for the IFU1 fetch sequencer. Includes a    |
// |               PC counter and a single-outstanding memory model; the        |
// |               expected instruction stream is derived from fetch rules and  |
// |               checked by an independent monitor on every IDU handshake.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ysyx23060136_ifu_fetch_ctrl;

  localparam int          BITS_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [BITS_W-1:0] IFU1_pc;
  logic              BRANCH_PCSrc;
  logic              IFU_stallIF;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [BITS_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [BITS_W-1:0] mem_resp_data;
  logic              mem_resp_err;
  logic              IFU_valid;
  logic              IDU_ready;
  logic [BITS_W-1:0] IFU_inst;
  logic [BITS_W-1:0] IFU_pc;
  logic              IFU_err;

  ysyx23060136_ifu_fetch_ctrl #(.BITS_W(BITS_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .IFU1_pc        (IFU1_pc),
    .BRANCH_PCSrc   (BRANCH_PCSrc),
    .IFU_stallIF    (IFU_stallIF),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .IFU_valid      (IFU_valid),
    .IDU_ready      (IDU_ready),
    .IFU_inst       (IFU_inst),
    .IFU_pc         (IFU_pc),
    .IFU_err        (IFU_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } item_t;

  int    checks   = 0;
  int    failures = 0;
  item_t exp_q[$];
  bit    mon_en   = 1'b0;

  // Environment state.
  logic [31:0] pc_next;      // PC counter value for the next cycle
  logic [31:0] exp_pc;       // address the next request must carry
  logic [31:0] tgt;          // current branch target
  bit          out_pend;     // memory holds an outstanding read
  logic [31:0] out_addr;
  int          out_lat;
  bit          out_stale;    // a redirect happened while it was outstanding
  int          bp_left;
  int          directed_left;
  bit          first;
  bit          abort;
  int          idle_cnt;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h8000_0413;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[4:2] == 3'b100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the buffer must hold exactly the oldest undelivered fetch.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid_vs_model", {31'd0, IFU_valid}, {31'd0, exp_q.size() != 0});
      if (IFU_valid && exp_q.size() != 0) begin
        check("out_pc",   IFU_pc,           exp_q[0].pc);
        check("out_inst", IFU_inst,         exp_q[0].inst);
        check("out_err",  {31'd0, IFU_err}, {31'd0, exp_q[0].err});
        if (IDU_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive();
    IFU1_pc = pc_next;
    if (directed_left > 0) begin
      BRANCH_PCSrc  = 1'b0;
      mem_req_ready = 1'b1;
      IDU_ready     = 1'b1;
    end else begin
      BRANCH_PCSrc  = ($urandom_range(0, 9) == 0);
      if (BRANCH_PCSrc) tgt = 32'h8000_1000 + (32'($urandom_range(0, 255)) << 2);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      if (bp_left > 0) begin
        IDU_ready = 1'b0;
        bp_left--;
      end else if ($urandom_range(0, 15) == 0) begin
        IDU_ready = 1'b0;
        bp_left   = $urandom_range(2, 6);
      end else begin
        IDU_ready = ($urandom_range(0, 5) != 0);
      end
    end
    mem_resp_valid = out_pend && (out_lat == 0);
    mem_resp_data  = out_pend ? mem_data(out_addr) : 32'hdead_beef;
    mem_resp_err   = out_pend ? mem_err(out_addr) : 1'b0;
  endtask

  // Applies the fetch rules to what happened this cycle and pushes the
  // instruction the IDU should eventually see.
  task automatic model_step();
    bit req_hs, acc, keep;
    req_hs = mem_req_valid && mem_req_ready;
    acc    = mem_resp_valid && mem_resp_ready;
    keep   = acc && !out_stale && !BRANCH_PCSrc;

    if (mem_req_valid) begin
      check("req_addr", mem_req_addr, exp_pc);
      check("req_while_pending", {31'd0, out_pend}, 32'd0);
    end
    if (BRANCH_PCSrc) check("req_during_redirect", {31'd0, mem_req_valid}, 32'd0);
    check("stall", {31'd0, IFU_stallIF}, {31'd0, !(BRANCH_PCSrc || keep)});
    if (IFU_valid && !IDU_ready) check("backpressure", {31'd0, mem_resp_ready}, 32'd0);

    if (keep) begin
      exp_q.push_back('{pc: out_addr, inst: mem_data(out_addr), err: mem_err(out_addr)});
      exp_pc = exp_pc + 32'd4;
    end
    if (BRANCH_PCSrc) begin
      exp_q.delete();
      exp_pc = tgt;
    end

    if (acc) out_pend = 1'b0;
    else if (out_pend && BRANCH_PCSrc) out_stale = 1'b1;
    if (out_pend && !acc && out_lat > 0) out_lat--;
    if (req_hs) begin
      out_pend  = 1'b1;
      out_addr  = mem_req_addr;
      out_lat   = (directed_left > 0) ? 0 : $urandom_range(0, 3);
      out_stale = 1'b0;
    end

    // PC counter: loads the target or steps by 4 whenever released.
    if (!IFU_stallIF) pc_next = BRANCH_PCSrc ? tgt : IFU1_pc + 32'd4;
    else pc_next = IFU1_pc;

    if (req_hs || acc) idle_cnt = 0;
    else idle_cnt++;
    if (idle_cnt > 40) begin
      check("progress_timeout", 32'(idle_cnt), 32'd0);
      abort = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    #1;
    if (first) begin
      check("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("first_req_addr", mem_req_addr, RESET_PC);
      first = 1'b0;
    end
    model_step();
    if (directed_left > 0) directed_left--;
  endtask

  task automatic env_reset();
    exp_q.delete();
    out_pend       = 1'b0;
    out_addr       = '0;
    out_lat        = 0;
    out_stale      = 1'b0;
    bp_left        = 0;
    idle_cnt       = 0;
    pc_next        = RESET_PC;
    exp_pc         = RESET_PC;
    tgt            = RESET_PC;
    IFU1_pc        = RESET_PC;
    BRANCH_PCSrc   = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    IDU_ready      = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_valid",      {31'd0, IFU_valid},      32'd0);
    check("rst_inst",       IFU_inst,                32'd0);
    check("rst_pc",         IFU_pc,                  32'd0);
    check("rst_err",        {31'd0, IFU_err},        32'd0);
    check("rst_stall",      {31'd0, IFU_stallIF},    32'd1);
    check("rst_req_valid",  {31'd0, mem_req_valid},  32'd0);
    check("rst_resp_ready", {31'd0, mem_resp_ready}, 32'd0);
  endtask

  task automatic release_and_run(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("idle_no_req", {31'd0, mem_req_valid}, 32'd0);
    mon_en        = 1'b1;
    first         = 1'b1;
    directed_left = 12;
    for (int i = 0; i < n && !abort; i++) cycle();
  endtask

  initial begin
    abort = 1'b0;
    rst   = 1'b0;
    env_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();

    release_and_run(600);

    // Reset while a read is outstanding must clear everything at once.
    if (!abort) begin
      for (int k = 0; k < 50 && !out_pend; k++) cycle();
      check("reach_wait", {31'd0, out_pend}, 32'd1);
      @(posedge clk);
      #3;
      rst    = 1'b0;
      mon_en = 1'b0;
      #1;
      check_reset_outputs();
      env_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      release_and_run(400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
